// File: rtl/mccp_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - Default data/address width, core count and memory latency.
//   - Arbiter FSM state encoding.
package mccp_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_CORE_NUM    = 4;
    localparam int DEF_MEM_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req        - per-core request vector
//   last_grant - index of the most recently granted core
//   valid      - at least one request is present
//   index      - winning core: first requester found searching upward from
//                last_grant+1, wrapping modulo CORE_NUM
module rr_picker #(
    parameter int CORE_NUM = 4,
    parameter int IDX_W    = 2
) (
    input  logic [CORE_NUM-1:0] req,
    input  logic [IDX_W-1:0]    last_grant,
    output logic                valid,
    output logic [IDX_W-1:0]    index
);

    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest distance down to the nearest so that the
    // nearest requester is the last assignment and therefore wins.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        cand_idx = '0;
        for (int d = CORE_NUM; d >= 1; d--) begin
            cand_idx = IDX_W'((int'(last_grant) + d) % CORE_NUM);
            if (req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port among CORE_NUM cores,
// with exactly one transaction in flight at a time.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   request/wren          - per-core request and write enable
//   address/writedata     - packed per-core address/data, core i at [i*WIDTH +: WIDTH]
//   response              - one-cycle completion pulse for the served core
//   readdata              - last captured read data, shared by all cores
//   mem_address/mem_writedata/mem_wren/mem_rden/mem_readdata - memory port
//   busy                  - transaction in flight
//   grant_idx             - current/last granted core
module mem_arbiter
    import mccp_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CORE_NUM    = DEF_CORE_NUM,
    parameter int IDX_W       = $clog2(CORE_NUM),
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CORE_NUM-1:0]       request,
    input  logic [CORE_NUM-1:0]       wren,
    input  logic [CORE_NUM*WIDTH-1:0] address,
    input  logic [CORE_NUM*WIDTH-1:0] writedata,
    output logic [CORE_NUM-1:0]       response,
    output logic [WIDTH-1:0]          readdata,
    output logic [WIDTH-1:0]          mem_address,
    output logic [WIDTH-1:0]          mem_writedata,
    output logic                      mem_wren,
    output logic                      mem_rden,
    input  logic [WIDTH-1:0]          mem_readdata,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_idx
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    arb_state_e       state_q,    state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             wren_q,     wren_d;
    logic [WIDTH-1:0] addr_q,     addr_d;
    logic [WIDTH-1:0] wdata_q,    wdata_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [WIDTH-1:0] core_addr  [CORE_NUM];
    logic [WIDTH-1:0] core_wdata [CORE_NUM];

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    generate
        for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_unpack
            assign core_addr[gi]  = address[gi*WIDTH +: WIDTH];
            assign core_wdata[gi] = writedata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Searching from the last grant gives a core that keeps requesting
    // after its response the lowest priority in the next arbitration.
    rr_picker #(
        .CORE_NUM (CORE_NUM),
        .IDX_W    (IDX_W)
    ) u_rr_picker (
        .req        (request),
        .last_grant (grant_idx_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        wren_d      = wren_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        readdata_d  = readdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    wren_d      = wren[pick_idx];
                    addr_d      = core_addr[pick_idx];
                    wdata_d     = core_wdata[pick_idx];
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Memory data is valid during the last WAIT cycle only.
                if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    if (!wren_q) begin
                        readdata_d = mem_readdata;
                    end
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= IDX_W'(CORE_NUM - 1);
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            readdata_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            readdata_q  <= readdata_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        response = '0;
        if (state_q == ST_RESP) begin
            response[grant_idx_q] = 1'b1;
        end
    end

    assign mem_wren      = (state_q == ST_ACCESS) &&  wren_q;
    assign mem_rden      = (state_q == ST_ACCESS) && !wren_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign readdata      = readdata_q;
    assign busy          = (state_q != ST_IDLE);
    assign grant_idx     = grant_idx_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   request;
    logic [N-1:0]   wren;
    logic [N*W-1:0] address;
    logic [N*W-1:0] writedata;
    logic [N-1:0]   response;
    logic [W-1:0]   readdata;
    logic [W-1:0]   mem_address;
    logic [W-1:0]   mem_writedata;
    logic           mem_wren;
    logic           mem_rden;
    logic [W-1:0]   mem_readdata;
    logic           busy;
    logic [1:0]     grant_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .request       (request),
        .wren          (wren),
        .address       (address),
        .writedata     (writedata),
        .response      (response),
        .readdata      (readdata),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_wren      (mem_wren),
        .mem_rden      (mem_rden),
        .mem_readdata  (mem_readdata),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    // Memory model: data appears MEM_LATENCY (2) cycles after the read strobe,
    // garbage at every other time.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    logic [1:0]  rd_pipe = 2'b00;
    logic [31:0] a_pipe0 = '0;
    logic [31:0] a_pipe1 = '0;
    always @(posedge clk) begin
        rd_pipe <= {rd_pipe[0], mem_rden};
        a_pipe0 <= mem_address;
        a_pipe1 <= a_pipe0;
    end
    assign mem_readdata = rd_pipe[1] ? mem_data(a_pipe1) : 32'hBAD0BAD0;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; request = '0; wren = '0; address = '0; writedata = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (response !== 4'b0 || busy !== 1'b0 || mem_wren !== 1'b0 || mem_rden !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: response=%b busy=%b wren=%b rden=%b required 0000 0 0 0",
                     response, busy, mem_wren, mem_rden);
        end
        checks++;
        if (readdata !== 32'h0 || mem_address !== 32'h0 || mem_writedata !== 32'h0 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL reset_data: readdata=%h addr=%h wdata=%h grant=%0d required 0 0 0 3",
                     readdata, mem_address, mem_writedata, grant_idx);
        end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        do_reset();
        request[2] = 1'b1; wren[2] = 1'b0; address[2*W +: W] = 32'h10;
        @(negedge clk); // t+1
        checks++;
        if (mem_rden !== 1'b1 || mem_wren !== 1'b0 || mem_address !== 32'h10 || busy !== 1'b1 || grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL read_strobe: rden=%b wren=%b addr=%h busy=%b grant=%0d required 1 0 00000010 1 2",
                     mem_rden, mem_wren, mem_address, busy, grant_idx);
        end
        request = '0;
        @(negedge clk); // t+2
        checks++;
        if (mem_rden !== 1'b0 || response !== 4'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_wait: rden=%b response=%b busy=%b required 0 0000 1", mem_rden, response, busy);
        end
        @(negedge clk); // t+3
        checks++;
        if (readdata !== 32'h0 || response !== 4'b0) begin
            errors++;
            $display("FAIL read_early: readdata=%h response=%b required 00000000 0000", readdata, response);
        end
        @(negedge clk); // t+4
        checks++;
        if (response !== 4'b0100 || readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_resp: response=%b readdata=%h required 0100 deadbeef", response, readdata);
        end
        @(negedge clk); // t+5
        checks++;
        if (response !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_done: response=%b busy=%b required 0000 0", response, busy);
        end
        $display("test_single_read core2 addr=10 readdata=%h", readdata);
    endtask

    task automatic test_single_write();
        request[1] = 1'b1; wren[1] = 1'b1; address[1*W +: W] = 32'h20; writedata[1*W +: W] = 32'h55;
        @(negedge clk); // t+1
        checks++;
        if (mem_wren !== 1'b1 || mem_rden !== 1'b0 || mem_address !== 32'h20 || mem_writedata !== 32'h55) begin
            errors++;
            $display("FAIL write_strobe: wren=%b rden=%b addr=%h wdata=%h required 1 0 00000020 00000055",
                     mem_wren, mem_rden, mem_address, mem_writedata);
        end
        request = '0; wren = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); // t+4
        checks++;
        if (response !== 4'b0010 || readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_resp: response=%b readdata=%h required 0010 deadbeef", response, readdata);
        end
        @(negedge clk);
        $display("test_single_write core1 addr=20 data=55");
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int i = 0; i < N; i++) address[i*W +: W] = 32'h100 + i*4;
        wren = '0;
        request = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int exp_core;
            exp_core = k % N;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (response === 4'b0 && n < 12);
            checks++;
            if (response !== (4'b1 << exp_core) || grant_idx !== 2'(exp_core) ||
                n !== ((k == 0) ? 4 : 5) || readdata !== mem_data(32'h100 + exp_core*4)) begin
                errors++;
                $display("FAIL rr_txn%0d: response=%b grant=%0d cycles=%0d readdata=%h required core %0d cycles %0d data %h",
                         k, response, grant_idx, n, readdata, exp_core, (k == 0) ? 4 : 5,
                         mem_data(32'h100 + exp_core*4));
            end
            $display("test_round_robin txn %0d core=%0d cycles=%0d", k, grant_idx, n);
        end
        request = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        request = 4'b1001; wren = 4'b0001;
        address[0*W +: W] = 32'h200; writedata[0*W +: W] = 32'h1234;
        address[3*W +: W] = 32'h30;
        for (int k = 0; k < 9; k++) begin
            int exp_core;
            exp_core = (k == 1) ? 3 : 0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (response === 4'b0 && n < 12);
            checks++;
            if (response !== (4'b1 << exp_core) || n !== ((k == 0) ? 4 : 5)) begin
                errors++;
                $display("FAIL b2b_txn%0d: response=%b cycles=%0d required core %0d cycles %0d",
                         k, response, n, exp_core, (k == 0) ? 4 : 5);
            end
            if (k == 1) begin
                request[3] = 1'b0;
                checks++;
                if (readdata !== mem_data(32'h30)) begin
                    errors++;
                    $display("FAIL b2b_read: readdata=%h required %h", readdata, mem_data(32'h30));
                end
            end
            $display("test_back_to_back txn %0d response=%b", k, response);
        end
        request = '0; wren = '0;
        @(negedge clk);
    endtask

    task automatic test_drop_request();
        int strobes;
        // grant_idx is 0 here, core 1 is the only requester
        request[1] = 1'b1; wren[1] = 1'b0; address[1*W +: W] = 32'h40;
        @(negedge clk); // t+1
        checks++;
        if (mem_rden !== 1'b1 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL drop_strobe: rden=%b grant=%0d required 1 1", mem_rden, grant_idx);
        end
        @(negedge clk); // t+2, in WAIT
        request[1] = 1'b0;
        address[1*W +: W] = 32'h44;
        @(negedge clk);
        @(negedge clk); // t+4
        checks++;
        if (response !== 4'b0010 || readdata !== mem_data(32'h40)) begin
            errors++;
            $display("FAIL drop_resp: response=%b readdata=%h required 0010 %h",
                     response, readdata, mem_data(32'h40));
        end
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rden === 1'b1 || mem_wren === 1'b1 || busy === 1'b1) strobes++;
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL drop_dup: extra active cycles=%0d required 0", strobes);
        end
        $display("test_drop_request core1 readdata=%h", readdata);
    endtask

    task automatic test_reset_mid();
        int pulses;
        request[2] = 1'b1; wren[2] = 1'b0; address[2*W +: W] = 32'h50;
        @(negedge clk); // t+1
        request = '0;
        @(negedge clk); // t+2, in WAIT
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (response !== 4'b0 || busy !== 1'b0 || mem_rden !== 1'b0 || mem_wren !== 1'b0 ||
            readdata !== 32'h0 || mem_address !== 32'h0 || mem_writedata !== 32'h0 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL midreset_state: resp=%b busy=%b rden=%b wren=%b rd=%h addr=%h wdata=%h grant=%0d required all 0, grant 3",
                     response, busy, mem_rden, mem_wren, readdata, mem_address, mem_writedata, grant_idx);
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (response !== 4'b0 || busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midreset_pulse: active cycles=%0d required 0", pulses);
        end
        request = 4'b0101; wren = '0; address[0*W +: W] = 32'h60;
        @(negedge clk);
        checks++;
        if (grant_idx !== 2'd0 || mem_rden !== 1'b1 || mem_address !== 32'h60) begin
            errors++;
            $display("FAIL midreset_grant: grant=%0d rden=%b addr=%h required 0 1 00000060",
                     grant_idx, mem_rden, mem_address);
        end
        request = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (response !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_resp: response=%b required 0001", response);
        end
        $display("test_reset_mid next grant=%0d", grant_idx);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_back_to_back();
        test_drop_request();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter CORE_NUM, default 4, number of requesting cores.
REQ-003 SHALL have parameter IDX_W, default 2, grant index width, equal to clog2(CORE_NUM).
REQ-004 SHALL have parameter MEM_LATENCY, default 2, cycles from memory strobe to valid mem_readdata (minimum 1).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port request, input, CORE_NUM, per-core request.
REQ-008 SHALL have port wren, input, CORE_NUM, per-core write enable.
REQ-009 SHALL have port address, input, CORE_NUM*WIDTH, packed per-core address; core i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port writedata, input, CORE_NUM*WIDTH, packed per-core write data.
REQ-011 SHALL have port response, output, CORE_NUM, one-cycle completion pulse per core.
REQ-012 SHALL have port readdata, output, WIDTH, registered read data broadcast to all cores.
REQ-013 SHALL have ports mem_address (output, WIDTH), mem_writedata (output, WIDTH), mem_wren (output, 1), mem_rden (output, 1), mem_readdata (input, WIDTH).
REQ-014 SHALL have port busy, output, 1, transaction in flight; port grant_idx, output, IDX_W, current/last granted core.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, WAIT, RESP; only one transaction in flight.
REQ-016 IDLE: any request bit high -> latch winner, its wren, address and writedata; go to ACCESS next cycle.
REQ-017 Winner SHALL be chosen round-robin: search from grant_idx+1, wrapping modulo CORE_NUM; the lowest-distance request wins.
REQ-018 ACCESS (1 cycle): drive latched mem_address and mem_writedata; assert mem_wren if wren was latched high, else mem_rden; go to WAIT.
REQ-019 WAIT SHALL last exactly MEM_LATENCY cycles; on the edge ending its last cycle, capture mem_readdata into readdata, for reads only.
REQ-020 RESP (1 cycle): response[grant_idx]=1, all other response bits 0; go to IDLE.
REQ-021 Latency: request seen in IDLE at cycle t -> strobe at t+1 -> response at t+2+MEM_LATENCY; identical for reads and writes.
REQ-022 Request, address and wren inputs SHALL be ignored outside IDLE; dropping a request mid-transaction does not cancel it, and its response still pulses.
REQ-023 A core holding request after its RESP SHALL be re-arbitrated in the next IDLE with lowest priority.
REQ-024 mem_wren and mem_rden SHALL never be high together, and SHALL be 0 outside ACCESS.
REQ-025 readdata SHALL hold its value until the next read capture; a write leaves it unchanged.
REQ-026 busy SHALL be 1 in ACCESS, WAIT and RESP.

Reset
REQ-027 On rst_n=0 at an edge: state=IDLE, grant_idx=CORE_NUM-1 (core 0 wins first), response=0, readdata=0, mem_* outputs=0, busy=0, WAIT counter=0.
REQ-028 Reset mid-transaction SHALL abort it: no response pulse, strobes low from the next cycle.

Structure
REQ-029 Shared package mccp_pkg SHALL hold the FSM state enum and the default WIDTH/CORE_NUM/MEM_LATENCY constants.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: req vector, last grant; outputs: valid, index).

Verification
REQ-031 Single read: core 2 reads 0x10, memory returns 0xDEADBEEF -> mem_rden at t+1 with mem_address=0x10, response[2] and readdata=0xDEADBEEF at t+4 (MEM_LATENCY=2).
REQ-032 Single write: core 1 writes 0x55 to 0x20 -> mem_wren=1 with mem_writedata=0x55 at t+1, response[1] at t+4, readdata unchanged.
REQ-033 All four requesting continuously after reset -> grant order 0,1,2,3,0, one response every 5 cycles, no starvation.
REQ-034 Core 0 holds request across 8 back-to-back writes while core 3 requests once -> core 3 is served after core 0's first transaction.
REQ-035 Core 1 drops request during WAIT -> response[1] still pulses; no duplicate transaction is issued.
REQ-036 rst_n low during WAIT -> no response pulse; all outputs match their reset values; next grant goes to core 0.
